mem_access: RTL and testbench

Memory-stage access controller sitting on the read side of the EX/MEM pipeline register. It decodes `MEM_ctrl` and `ALUres` from EX/MEM, drives a multi-cycle request/response data-memory port, and aligns and sign/zero-extends load data for MEM/WB. It stalls the pipeline, freezing PC, IF/ID, ID/EX and EX/MEM, until the access completes.

---
 rtl/mem_access.sv | 200 ++++++++++++++++++++
 tb/tb_mem_access.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-stage access controller: decodes EX/MEM control, runs a request/response
// data-memory handshake, stalls the pipeline, and aligns/extends load data.
// Optional macro MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into traps.
module mem_access #(
    parameter int MEM_CTRL_WID = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             ALUres_in,
    input  logic [31:0]             data2_in,
    input  logic [MEM_CTRL_WID-1:0] MEM_ctrl_in,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [31:0]             dmem_addr,
    output logic [3:0]              dmem_be,
    output logic [31:0]             dmem_wdata,
    input  logic                    dmem_ready,
    input  logic                    dmem_rvalid,
    input  logic [31:0]             dmem_rdata,
    output logic [31:0]             mem_data_out,
    output logic                    stall_out,
    output logic                    misalign_exc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        access_s;
    logic        is_load_s;
    logic        misalign_s;
    logic        trap_r;
    logic [2:0]  funct3_s;
    logic [1:0]  off_s;

    assign mem_read_s  = MEM_ctrl_in[MEM_CTRL_WID-1];
    assign mem_write_s = MEM_ctrl_in[MEM_CTRL_WID-2];
    assign funct3_s    = MEM_ctrl_in[2:0];
    assign off_s       = ALUres_in[1:0];
    assign access_s    = mem_read_s | mem_write_s;
    // Read+write together is resolved as a load.
    assign is_load_s   = mem_read_s;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << off;
            3'b001:  be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3)
            3'b000:  w = {4{d[7:0]}};
            3'b001:  w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = w;
        endcase
        return r;
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic ld, input logic [2:0] f3,
                                           input logic [1:0] off);
        logic m;
        if (ld) begin
            case (f3)
                3'b000, 3'b100: m = 1'b0;
                3'b001, 3'b101: m = off[0];
                default:        m = (off != 2'b00);
            endcase
        end else begin
            case (f3)
                3'b000:  m = 1'b0;
                3'b001:  m = off[0];
                default: m = (off != 2'b00);
            endcase
        end
        return m;
    endfunction

    assign misalign_s = is_misaligned(is_load_s, funct3_s, off_s);
`else
    assign misalign_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (access_s) begin
                    state_nxt_s = misalign_s ? ST_DONE : ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_ready) begin
                    state_nxt_s = is_load_s ? ST_WAIT : ST_DONE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode; gated by reset so the stall and request drop the instant reset asserts.
    always_comb begin
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = 32'h0000_0000;
        dmem_be      = 4'b0000;
        dmem_wdata   = 32'h0000_0000;
        stall_out    = 1'b0;
        misalign_exc = 1'b0;
        if (!rst) begin
            stall_out = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: stall_out = access_s;
                ST_REQ: begin
                    dmem_req   = 1'b1;
                    stall_out  = 1'b1;
                    dmem_we    = ~is_load_s;
                    dmem_addr  = {ALUres_in[31:2], 2'b00};
                    dmem_be    = is_load_s ? 4'b1111 : store_be(funct3_s, off_s);
                    dmem_wdata = is_load_s ? 32'h0000_0000 : store_wdata(funct3_s, data2_in);
                end
                ST_WAIT: stall_out = 1'b1;
                ST_DONE: misalign_exc = trap_r;
                default: stall_out = 1'b0;
            endcase
        end
    end

    // Load result and trap flag; the result only changes when a load completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_data_out <= 32'h0000_0000;
            trap_r       <= 1'b0;
        end else begin
            if (state_r == ST_WAIT && dmem_rvalid) begin
                mem_data_out <= load_extend(funct3_s, off_s, dmem_rdata);
            end else begin
                mem_data_out <= mem_data_out;
            end
            if (state_r == ST_IDLE) begin
                trap_r <= access_s & misalign_s;
            end else begin
                trap_r <= trap_r;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Table-driven bench for mem_access with a scoreboard queue of expected access results.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_res;
    logic [31:0] data2;
    logic [4:0]  mem_ctrl;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] mem_data_out;
    logic        stall_out;
    logic        misalign_exc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access #(.MEM_CTRL_WID(5)) dut (
        .clk(clk), .rst(rst),
        .ALUres_in(alu_res), .data2_in(data2), .MEM_ctrl_in(mem_ctrl),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_data_out(mem_data_out), .stall_out(stall_out), .misalign_exc(misalign_exc)
    );

    typedef struct {
        logic [4:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] data2;
        logic [31:0] rdata;
        int          rdy_dly;
        int          rv_dly;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] daddr;
        logic        we;
        int          req_cyc;
        int          stalls;
        logic [31:0] dout;
        int          exc;
    } vec_t;

    vec_t tbl [13];
    vec_t sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        vec_t        e;
        int          stalls = 0;
        int          reqc = 0;
        int          exc = 0;
        int          after = 0;
        logic        done = 1'b0;
        logic        rdy_given = 1'b0;
        logic [3:0]  be_o = 4'h0;
        logic [31:0] wd_o = 32'h0;
        logic [31:0] ad_o = 32'h0;
        logic        we_o = 1'b0;
        @(posedge clk);
        #1;
        alu_res    = v.addr;
        data2      = v.data2;
        mem_ctrl   = v.ctrl;
        dmem_rdata = v.rdata;
        sb_q.push_back(v);
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            dmem_ready  = 1'b0;
            dmem_rvalid = 1'b0;
            if (stall_out) stalls++;
            if (misalign_exc) exc++;
            if (dmem_req) begin
                reqc++;
                if (reqc == 1) begin
                    be_o = dmem_be; wd_o = dmem_wdata; ad_o = dmem_addr; we_o = dmem_we;
                end
                if (reqc > v.rdy_dly) begin
                    dmem_ready = 1'b1;
                    rdy_given  = 1'b1;
                end
            end else if (rdy_given) begin
                after++;
                if (after == v.rv_dly) dmem_rvalid = 1'b1;
            end
            if (!stall_out) done = 1'b1;
        end
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        check($sformatf("v%0d completed", idx), {31'h0, done}, 32'h1);
        e = sb_q.pop_front();
        check($sformatf("v%0d stall_cycles", idx), stalls, e.stalls);
        check($sformatf("v%0d req_cycles", idx), reqc, e.req_cyc);
        check($sformatf("v%0d exc_pulses", idx), exc, e.exc);
        check($sformatf("v%0d mem_data_out", idx), mem_data_out, e.dout);
        if (e.req_cyc > 0) begin
            check($sformatf("v%0d addr", idx), ad_o, e.daddr);
            check($sformatf("v%0d we", idx), {31'h0, we_o}, {31'h0, e.we});
            check($sformatf("v%0d be", idx), {28'h0, be_o}, {28'h0, e.be});
            if (e.we) check($sformatf("v%0d wdata", idx), wd_o, e.wdata);
        end
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    localparam logic [31:0] D10 = 32'h0BADF00D;
`else
    localparam logic [31:0] D10 = 32'h11223344;
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{5'b01010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 4'hF, 32'hDEADBEEF, 32'h100, 1'b1, 1, 2, 32'h0, 0};
        tbl[1]  = '{5'b10000, 32'h103, 32'h0, 32'h80FF1234, 0, 2, 4'hF, 32'h0, 32'h100, 1'b0, 1, 4, 32'hFFFFFF80, 0};
        tbl[2]  = '{5'b10101, 32'h102, 32'h0, 32'hBEEF0000, 0, 1, 4'hF, 32'h0, 32'h100, 1'b0, 1, 3, 32'h0000BEEF, 0};
        tbl[3]  = '{5'b01000, 32'h101, 32'h000000AB, 32'h0, 0, 0, 4'b0010, 32'hABABABAB, 32'h100, 1'b1, 1, 2, 32'h0000BEEF, 0};
        tbl[4]  = '{5'b10001, 32'h100, 32'h0, 32'h12348001, 2, 1, 4'hF, 32'h0, 32'h100, 1'b0, 3, 5, 32'hFFFF8001, 0};
        tbl[5]  = '{5'b01001, 32'h102, 32'h0000CAFE, 32'h0, 1, 0, 4'b1100, 32'hCAFECAFE, 32'h100, 1'b1, 2, 3, 32'hFFFF8001, 0};
        tbl[6]  = '{5'b10100, 32'h101, 32'h0, 32'h0000F500, 0, 1, 4'hF, 32'h0, 32'h100, 1'b0, 1, 3, 32'h000000F5, 0};
        tbl[7]  = '{5'b10010, 32'h104, 32'h0, 32'h76543210, 0, 1, 4'hF, 32'h0, 32'h104, 1'b0, 1, 3, 32'h76543210, 0};
        tbl[8]  = '{5'b00000, 32'h100, 32'hFFFFFFFF, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1'b0, 0, 0, 32'h76543210, 0};
        tbl[9]  = '{5'b11010, 32'h108, 32'hFFFFFFFF, 32'h0BADF00D, 0, 1, 4'hF, 32'h0, 32'h108, 1'b0, 1, 3, 32'h0BADF00D, 0};
`ifdef MEM_MISALIGN_TRAP_EN
        tbl[10] = '{5'b10010, 32'h102, 32'h0, 32'h11223344, 0, 1, 4'hF, 32'h0, 32'h100, 1'b0, 0, 1, 32'h0BADF00D, 1};
        tbl[12] = '{5'b01001, 32'h103, 32'h00001234, 32'h0, 0, 0, 4'b1100, 32'h12341234, 32'h100, 1'b1, 0, 1, D10, 1};
`else
        tbl[10] = '{5'b10010, 32'h102, 32'h0, 32'h11223344, 0, 1, 4'hF, 32'h0, 32'h100, 1'b0, 1, 3, 32'h11223344, 0};
        tbl[12] = '{5'b01001, 32'h103, 32'h00001234, 32'h0, 0, 0, 4'b1100, 32'h12341234, 32'h100, 1'b1, 1, 2, D10, 0};
`endif
        tbl[11] = '{5'b01111, 32'h10C, 32'h55AA55AA, 32'h0, 0, 0, 4'hF, 32'h55AA55AA, 32'h10C, 1'b1, 1, 2, D10, 0};

        // Reset state, with a load presented while reset is held.
        rst = 1'b0; alu_res = 32'h100; data2 = 32'h0; mem_ctrl = 5'b10010;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("reset dmem_req", {31'h0, dmem_req}, 32'h0);
        check("reset stall_out", {31'h0, stall_out}, 32'h0);
        check("reset mem_data_out", mem_data_out, 32'h0);
        check("reset misalign_exc", {31'h0, misalign_exc}, 32'h0);
        mem_ctrl = 5'b00000;
        rst = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(tbl[i], i);

        // Reset asserted while a load waits for its data.
        @(posedge clk);
        #1;
        mem_ctrl = 5'b10010; alu_res = 32'h200; dmem_rdata = 32'h12345678;
        @(negedge clk);
        check("rst_seq idle stall", {31'h0, stall_out}, 32'h1);
        @(negedge clk);
        check("rst_seq req", {31'h0, dmem_req}, 32'h1);
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        check("rst_seq wait stall", {31'h0, stall_out}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_seq req drop", {31'h0, dmem_req}, 32'h0);
        check("rst_seq stall drop", {31'h0, stall_out}, 32'h0);
        check("rst_seq data cleared", mem_data_out, 32'h0);
        mem_ctrl = 5'b00000;
        @(negedge clk);
        rst = 1'b1;
        dmem_rvalid = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("rst_seq late rvalid", mem_data_out, 32'h0);
        check("rst_seq bubble stall", {31'h0, stall_out}, 32'h0);
        @(negedge clk);
        check("rst_seq bubble req", {31'h0, dmem_req}, 32'h0);
        check("rst_seq bubble stall2", {31'h0, stall_out}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
